// File: rtl/switch_debounce.sv
// Per-bit switch debouncer: 2-flop synchronizer, stability counter, registered
// debounced level plus one-cycle rise/fall/any-change pulses.
module switch_debounce #(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             any_change
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable_nxt;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Count consecutive mismatch cycles; accept the new level on the last one.
    always_comb begin
        stable_nxt = sw_stable;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (sync2[i] != sw_stable[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            sw_stable  <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            any_change <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1      <= sw_raw;
            sync2      <= sync1;
            sw_stable  <= stable_nxt;
            sw_rise    <= stable_nxt & ~sw_stable;
            sw_fall    <= ~stable_nxt & sw_stable;
            any_change <= |(stable_nxt ^ sw_stable);
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
